// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using shift-add-3 (double dabble). One
// input bit is consumed per clock. Each output nibble can drive one
// BCD-to-7-segment decoder directly. With BLANK_LZ=1, leading zero digits
// are replaced by 4'hF, which the decoder renders as all segments off.
//
// Parameters:
//   WIDTH    - bit width of the binary input; a conversion takes WIDTH cycles
//   DIGITS   - number of BCD digits; 10**DIGITS must exceed 2**WIDTH-1
//   BLANK_LZ - 1 = blank leading zero digits (digit 0 is never blanked)
//
// Ports:
//   clk   in   system clock, rising edge
//   rst_n in   synchronous active-low reset; aborts a running conversion
//   start in   conversion request, accepted only while busy=0
//   bin   in   WIDTH-bit unsigned value, sampled on the accepting edge only
//   busy  out  high while shifting
//   done  out  one-cycle pulse marking a new result on bcd
//   bcd   out  packed digits, bcd[3:0] = units, bcd[7:4] = tens, ...
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;        // scratch / result width
  localparam int SW = BW + WIDTH;        // combined {scratch, shiftreg} width
  localparam int CW = $clog2(WIDTH + 1); // bit counter must hold WIDTH itself

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Add 3 to every digit that is 5 or more. Digits are corrected
  // independently; there is never a carry from one nibble into the next.
  function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Replace zero digits that only have zero digits above them with 4'hF.
  // The scan starts at the top digit and stops at the first nonzero one;
  // the units digit is outside the loop so it always shows its true value.
  function automatic logic [BW-1:0] blank_leading(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    logic          lead;
    r    = s;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (s[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  state_e            state_q,   state_d;
  logic [WIDTH-1:0]  shift_q,   shift_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q,     cnt_d;
  logic [BW-1:0]     bcd_q,     bcd_d;
  logic              done_q,    done_d;
  logic              busy_q,    busy_d;

  logic [BW-1:0]     adj_s;      // scratch after add-3 correction
  logic [SW-1:0]     shifted_s;  // {adj_s, shift_q} shifted left by one
  logic [BW-1:0]     final_s;    // scratch after the last shift

  // Next-state and datapath logic for the conversion FSM.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;

    adj_s     = add3_digits(scratch_q);
    shifted_s = {adj_s, shift_q} << 1;
    final_s   = shifted_s[SW-1:WIDTH];

    case (state_q)
      // DONE accepts a new request exactly like IDLE, which gives
      // back-to-back conversions with no idle cycle in between.
      S_IDLE, S_DONE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = {BW{1'b0}};
          cnt_d     = CW'(WIDTH);
          state_d   = S_SHIFT;
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_SHIFT: begin
        scratch_d = final_s;
        shift_d   = shifted_s[WIDTH-1:0];
        cnt_d     = cnt_q - CW'(1);
        // The shift taking cnt from 1 to 0 is the last one; its result is
        // published on the same edge.
        if (cnt_q == CW'(1)) begin
          if (BLANK_LZ != 0) begin
            bcd_d = blank_leading(final_s);
          end else begin
            bcd_d = final_s;
          end
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SHIFT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= {WIDTH{1'b0}};
      scratch_q <= {BW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      bcd_q     <= {BW{1'b0}};
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

  bin_to_bcd_seq_chk #(
    .WIDTH    (WIDTH),
    .DIGITS   (DIGITS),
    .BLANK_LZ (BLANK_LZ)
  ) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy_q),
    .done  (done_q),
    .bcd   (bcd_q)
  );

endmodule

// -----------------------------------------------------------------------------
// bin_to_bcd_seq_chk
//
// Simulation-only property checks for bin_to_bcd_seq: parameter legality,
// busy/done exclusivity, single-cycle done pulses and legal digit codes.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset of the converter
//   busy, done  converter status outputs
//   bcd         converter result
// -----------------------------------------------------------------------------
module bin_to_bcd_seq_chk #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                busy,
  input  logic                done,
  input  logic [4*DIGITS-1:0] bcd
);

  // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
  function automatic bit digits_sufficient();
    longint p;
    longint max_val;
    p = 64'sd1;
    for (int i = 0; i < DIGITS; i++) begin
      p = p * 64'sd10;
    end
    max_val = (64'sd1 <<< WIDTH) - 64'sd1;
    return (p > max_val);
  endfunction

  localparam bit LEGAL = digits_sufficient();

  a_param_legal: assert property (@(posedge clk) LEGAL);

  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(busy && done));

  a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    a_digit_code: assert property (@(posedge clk) disable iff (!rst_n)
      (bcd[4*g +: 4] <= 4'd9) || ((BLANK_LZ != 0) && (bcd[4*g +: 4] == 4'hF)));
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;
  localparam int LAT    = WIDTH;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [WIDTH-1:0] bin  = '0;
  logic            busy0, done0, busy1, done1;
  logic [BW-1:0]   bcd0, bcd1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy0), .done(done0), .bcd(bcd0));

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy1), .done(done1), .bcd(bcd1));

  // Reference: decimal digits by division; with blanking, every digit
  // position at or above the count of significant digits shows F.
  function automatic logic [BW-1:0] model(input int v, input bit blank);
    logic [BW-1:0] r;
    int t;
    int sig;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    if (blank) begin
      sig = 1;
      t = v / 10;
      while (t > 0) begin
        sig++;
        t = t / 10;
      end
      for (int i = sig; i < DIGITS; i++) r[4*i +: 4] = 4'hF;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, scramble bin after acceptance, wait for done.
  // Returns cycles from the sampling edge to done (-1 on timeout) and the
  // number of sampled cycles with busy high. Ends on the done cycle.
  task automatic run_conv(input logic [WIDTH-1:0] v, output int lat, output int busy_cnt);
    start = 1'b1;
    bin   = v;
    step();
    start = 1'b0;
    lat = -1;
    busy_cnt = 0;
    for (int n = 0; n <= 20; n++) begin
      if (done0) begin
        lat = n;
        break;
      end
      if (busy0) busy_cnt++;
      bin = WIDTH'($urandom);
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    step();
    step();
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
    n_checks++; if (bcd0 !== 12'h000) begin n_fail++; $display("FAIL reset_bcd0: got %h want 000", bcd0); end
    n_checks++; if (bcd1 !== 12'h000) begin n_fail++; $display("FAIL reset_bcd1: got %h want 000", bcd1); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_max();
    int lat, bc;
    run_conv(8'd255, lat, bc);
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL max_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (bc !== LAT) begin n_fail++; $display("FAIL max_busy_cycles: got %0d want %0d", bc, LAT); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL max_busy_at_done: got %b want 0", busy0); end
    n_checks++; if (bcd0 !== model(255, 1'b0)) begin n_fail++; $display("FAIL max_bcd0: got %h want %h", bcd0, model(255, 1'b0)); end
    n_checks++; if (bcd1 !== model(255, 1'b1)) begin n_fail++; $display("FAIL max_bcd1: got %h want %h", bcd1, model(255, 1'b1)); end
    step();
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL max_done_width: got %b want 0", done0); end
    n_checks++; if (bcd0 !== model(255, 1'b0)) begin n_fail++; $display("FAIL max_bcd_hold: got %h want %h", bcd0, model(255, 1'b0)); end
  endtask

  task automatic test_small();
    int vals[3] = '{0, 9, 100};
    int lat, bc;
    foreach (vals[i]) begin
      run_conv(WIDTH'(vals[i]), lat, bc);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL small_latency v=%0d: got %0d want %0d", vals[i], lat, LAT); end
      n_checks++; if (bcd0 !== model(vals[i], 1'b0)) begin n_fail++; $display("FAIL small_bcd0 v=%0d: got %h want %h", vals[i], bcd0, model(vals[i], 1'b0)); end
      n_checks++; if (bcd1 !== model(vals[i], 1'b1)) begin n_fail++; $display("FAIL small_bcd1 v=%0d: got %h want %h", vals[i], bcd1, model(vals[i], 1'b1)); end
    end
  endtask

  task automatic test_ignore_start();
    int cnt = 0;
    logic [BW-1:0] got0 = '0, got1 = '0;
    start = 1'b1;
    bin   = 8'd37;
    step();
    start = 1'b0;
    for (int n = 0; n < 25; n++) begin
      if (done0) begin
        cnt++;
        got0 = bcd0;
        got1 = bcd1;
      end
      if (n == 2 || n == 4) begin
        start = 1'b1;
        bin   = 8'd200;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", cnt); end
    n_checks++; if (got0 !== model(37, 1'b0)) begin n_fail++; $display("FAIL ignore_bcd0: got %h want %h", got0, model(37, 1'b0)); end
    n_checks++; if (got1 !== model(37, 1'b1)) begin n_fail++; $display("FAIL ignore_bcd1: got %h want %h", got1, model(37, 1'b1)); end
  endtask

  task automatic test_back_to_back();
    int vals[3] = '{17, 42, 99};
    int idx = 0;
    int last = -1;
    start = 1'b1;
    bin   = WIDTH'(vals[0]);
    step();
    for (int n = 0; n < 60; n++) begin
      if (done0) begin
        n_checks++; if (bcd0 !== model(vals[idx], 1'b0)) begin n_fail++; $display("FAIL b2b_bcd0 v=%0d: got %h want %h", vals[idx], bcd0, model(vals[idx], 1'b0)); end
        n_checks++; if (bcd1 !== model(vals[idx], 1'b1)) begin n_fail++; $display("FAIL b2b_bcd1 v=%0d: got %h want %h", vals[idx], bcd1, model(vals[idx], 1'b1)); end
        if (idx == 0) begin
          n_checks++; if (n !== LAT) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", n, LAT); end
        end else begin
          n_checks++; if ((n - last) !== LAT + 1) begin n_fail++; $display("FAIL b2b_period: got %0d want %0d", n - last, LAT + 1); end
        end
        last = n;
        idx++;
        if (idx == 3) begin
          start = 1'b0;
          break;
        end
        bin = WIDTH'(vals[idx]);
      end else if (last >= 0 && n == last + 1) begin
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle: got busy %b want 1", busy0); end
      end
      step();
    end
    start = 1'b0;
    n_checks++; if (idx !== 3) begin n_fail++; $display("FAIL b2b_result_count: got %0d want 3", idx); end
    step();
  endtask

  task automatic test_reset_abort();
    int spurious = 0;
    int lat, bc;
    start = 1'b1;
    bin   = 8'd123;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done0); end
    n_checks++; if (bcd0 !== 12'h000) begin n_fail++; $display("FAIL abort_bcd0: got %h want 000", bcd0); end
    n_checks++; if (bcd1 !== 12'h000) begin n_fail++; $display("FAIL abort_bcd1: got %h want 000", bcd1); end
    for (int n = 0; n < 20; n++) begin
      if (done0 || done1 || busy0) spurious++;
      step();
    end
    n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles want 0", spurious); end
    run_conv(8'd58, lat, bc);
    n_checks++; if (bcd0 !== model(58, 1'b0)) begin n_fail++; $display("FAIL abort_next_bcd0: got %h want %h", bcd0, model(58, 1'b0)); end
    n_checks++; if (bcd1 !== model(58, 1'b1)) begin n_fail++; $display("FAIL abort_next_bcd1: got %h want %h", bcd1, model(58, 1'b1)); end
  endtask

  task automatic test_sweep();
    int lat, bc;
    for (int v = 0; v < 256; v++) begin
      run_conv(WIDTH'(v), lat, bc);
      n_checks++; if (lat !== LAT || done1 !== 1'b1) begin n_fail++; $display("FAIL sweep_latency v=%0d: got %0d (done1 %b) want %0d", v, lat, done1, LAT); end
      n_checks++; if (bcd0 !== model(v, 1'b0)) begin n_fail++; $display("FAIL sweep_bcd0 v=%0d: got %h want %h", v, bcd0, model(v, 1'b0)); end
      n_checks++; if (bcd1 !== model(v, 1'b1)) begin n_fail++; $display("FAIL sweep_bcd1 v=%0d: got %h want %h", v, bcd1, model(v, 1'b1)); end
    end
  endtask

  task automatic test_random();
    int lat, bc, v, prev, gap;
    prev = 255;
    for (int k = 0; k < 40; k++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      n_checks++; if (bcd0 !== model(prev, 1'b0)) begin n_fail++; $display("FAIL rand_hold: got %h want %h", bcd0, model(prev, 1'b0)); end
      v = int'($urandom_range(0, 255));
      run_conv(WIDTH'(v), lat, bc);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL rand_latency v=%0d: got %0d want %0d", v, lat, LAT); end
      n_checks++; if (bcd0 !== model(v, 1'b0)) begin n_fail++; $display("FAIL rand_bcd0 v=%0d: got %h want %h", v, bcd0, model(v, 1'b0)); end
      n_checks++; if (bcd1 !== model(v, 1'b1)) begin n_fail++; $display("FAIL rand_bcd1 v=%0d: got %h want %h", v, bcd1, model(v, 1'b1)); end
      prev = v;
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_small();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    // Leave bcd at a known value (255) before the random hold checks.
    begin
      int lat, bc;
      run_conv(8'd255, lat, bc);
    end
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
